rcs_seq_addsub: RTL

//  Parametrised multi-cycle adder/subtractor; processes CHUNK bits per clock, LSB chunk first.

---
 rtl/rcs_pkg.sv | 21 ++
 rtl/rcs_seq_addsub_if.sv | 25 ++
 rtl/rcs_chunk.sv | 12 +
 rtl/rcs_seq_addsub.sv | 87 ++++++++
 4 files changed

// File: rtl/rcs_pkg.sv
// Shared types, mode constants and sizing helpers for the chunked ripple add/sub unit.
package rcs_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Index counter width; a single-chunk build still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rcs_seq_addsub_if.sv
// Request/result bundle between an operand source and rcs_seq_addsub.
interface rcs_seq_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/rcs_chunk.sv
// Combinational CHUNK-bit ripple adder; subtraction is handled by the caller inverting b.
module rcs_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);
endmodule

// File: rtl/rcs_seq_addsub.sv
// Multi-cycle adder/subtractor resolving CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a register.
module rcs_seq_addsub
  import rcs_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  rcs_seq_addsub_if.slave  bus
);
  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;

  // One adder slice shared by every chunk, fed by the index-selected operand slices.
  rcs_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[idx*CHUNK +: CHUNK]),
    .b    (b_q[idx*CHUNK +: CHUNK]),
    .cin  (c_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (bus.start) begin
          a_q   <= bus.a;
          b_q   <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
          c_q   <= (bus.mode == MODE_SUB) ? ~bus.cin : bus.cin;
          idx   <= '0;
          busy  <= 1'b1;
          state <= ST_RUN;
        end
      end else begin
        sum[idx*CHUNK +: CHUNK] <= ch_sum;
        c_q                     <= ch_cout;
        if (idx == LAST) begin
          // Sign of the result comes straight from the top chunk being written this edge.
          carry    <= ch_cout;
          overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ch_sum[CHUNK-1] != a_q[WIDTH-1]);
          done     <= 1'b1;
          busy     <= 1'b0;
          idx      <= '0;
          state    <= ST_IDLE;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.sum      = sum;
  assign bus.carry    = carry;
  assign bus.overflow = overflow;

endmodule
